// File: rtl/neo_pattern_sequencer.sv
// Frame producer for the NeoPixel driver: streams per-pixel colour levels,
// triggers repeated sends of the frame, then advances the animation phase.
module neo_pattern_sequencer #(
  parameter int                 NUM_PIXELS  = 5,
  parameter int                 LEVEL_W     = 8,
  parameter logic [LEVEL_W-1:0] MAX_LEVEL   = 8'h20,
  parameter int                 HOLD_FRAMES = 16,
  parameter int                 PIX_W       = $clog2(NUM_PIXELS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic [1:0]            mode,
  input  logic [NUM_PIXELS-1:0] pixel_mask,
  input  logic                  ready_to_load,
  input  logic                  ready_to_send,
  input  logic                  done_wait,
  output logic                  load_color,
  output logic [PIX_W-1:0]      pixel_index,
  output logic [1:0]            color_index,
  output logic [LEVEL_W-1:0]    color_level,
  output logic                  send_it,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int                 HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int                 PH_W      = LEVEL_W + 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [PIX_W-1:0]   PIX_LAST  = PIX_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_SEND, S_SEND} state_e;
  typedef enum logic [1:0] {M_STATIC, M_CHASE, M_FADE, M_RAINBOW} mode_e;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [1:0]         col_q, col_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [PIX_W-1:0]   chase_q, chase_d;
  logic [1:0]         rot_q, rot_d;
  logic [1:0]         m3_q, m3_d;
  logic [LEVEL_W-1:0] pattern;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= M_STATIC;
      pix_q   <= '0;
      col_q   <= '0;
      hold_q  <= '0;
      phase_q <= '0;
      chase_q <= '0;
      rot_q   <= '0;
      m3_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pix_q   <= pix_d;
      col_q   <= col_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
      chase_q <= chase_d;
      rot_q   <= rot_d;
      m3_q    <= m3_d;
    end
  end

  // m3_q tracks (rot + pix) mod 3 so the rainbow channel needs no divider.
  always_comb begin
    pattern = '0;
    case (mode_q)
      M_STATIC:  pattern = MAX_LEVEL;
      M_CHASE:   if (pix_q == chase_q) pattern = MAX_LEVEL;
      M_FADE:    pattern = phase_q[LEVEL_W] ? ~phase_q[LEVEL_W-1:0] : phase_q[LEVEL_W-1:0];
      M_RAINBOW: if (col_q == m3_q) pattern = MAX_LEVEL;
      default:   pattern = '0;
    endcase
    if (!pixel_mask[pix_q]) pattern = '0;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pix_d       = pix_q;
    col_d       = col_q;
    hold_d      = hold_q;
    phase_d     = phase_q;
    chase_d     = chase_q;
    rot_d       = rot_q;
    m3_d        = m3_q;
    load_color  = 1'b0;
    pixel_index = '0;
    color_index = '0;
    color_level = '0;
    send_it     = 1'b0;
    frame_done  = 1'b0;
    busy        = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (run) begin
          mode_d  = mode_e'(mode);
          pix_d   = '0;
          col_d   = '0;
          m3_d    = rot_q;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load_color  = ready_to_load;
        pixel_index = pix_q;
        color_index = col_q;
        color_level = pattern;
        if (ready_to_load) begin
          if (col_q == 2'd2) begin
            col_d = '0;
            if (pix_q == PIX_LAST) begin
              state_d = S_WAIT_SEND;
            end else begin
              pix_d = pix_q + PIX_W'(1);
              m3_d  = (m3_q == 2'd2) ? 2'd0 : m3_q + 2'd1;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      S_WAIT_SEND: begin
        if (ready_to_send) begin
          send_it = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (done_wait) begin
          if (hold_q < HOLD_LAST) begin
            hold_d  = hold_q + HOLD_W'(1);
            state_d = S_WAIT_SEND;
          end else begin
            hold_d     = '0;
            phase_d    = phase_q + PH_W'(1);
            chase_d    = (chase_q == PIX_LAST) ? '0 : chase_q + PIX_W'(1);
            rot_d      = (rot_q == 2'd2) ? 2'd0 : rot_q + 2'd1;
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
